bus_arbiter2: RTL and testbench

- Two-master bus arbiter for the Z80 system bus. Master A is the CPU path; master B is the DMA/debug path.
- Produces the registered `sel` that drives the downstream `mux2` instances (address/data/control toward memory/IO) and the `demux2` instances (read data back to masters).
- Produces per-master grants.
- Provides round-robin fairness, a bounded hold time with preemption, and a dead-bus turnaround so the downstream mux select never changes while a grant is live.

---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_arbiter2_hold_timer.sv | 34 +++
 rtl/bus_arbiter2.sv | 130 +++++++++++++
 tb/tb_bus_arbiter2.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master Z80 bus arbiter: FSM state encoding
// and master IDs matching the mux2/demux2 select polarity.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10,
    TURN  = 2'b11
  } arb_state_e;

  localparam logic MST_A = 1'b0;
  localparam logic MST_B = 1'b1;

endpackage

// File: rtl/bus_arbiter2_hold_timer.sv
// Saturating up-counter with synchronous clear/enable; tc_o flags count == MAX-1
// (the last cycle of a MAX-long window).
module hold_timer #(
  parameter int unsigned MAX = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX);
  localparam logic [W-1:0] TC    = (MAX == 0) ? '0 : W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LIMIT))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master bus arbiter: round-robin ties, bounded hold with preemption and a
// dead-bus turnaround on every ownership change. ARB_FIXED_PRIO_EN: A wins ties, only B is preemptible.
module bus_arbiter2
  import bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD    = 64,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic busy,
  output logic preempt
);

  localparam int unsigned TURN_N = (TURN_CYCLES < 1) ? 1 : TURN_CYCLES;

  arb_state_e state_q, state_d;
  logic sel_q, sel_d;
  logic last_q, last_d;
  logic preempt_q, preempt_d;
  logic gnt_a_q, gnt_b_q, busy_q;

  logic in_own, own_id, own_req, oth_req;
  logic hold_tc, turn_tc;
  logic tie_winner, preempt_ok, winner;

  assign in_own  = (state_q == OWN_A) || (state_q == OWN_B);
  assign own_id  = (state_q == OWN_B) ? MST_B : MST_A;
  assign own_req = (own_id == MST_B) ? req_b : req_a;
  assign oth_req = (own_id == MST_B) ? req_a : req_b;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_winner = MST_A;
  assign preempt_ok = (state_q == OWN_B);
`else
  assign tie_winner = ~last_q;
  assign preempt_ok = 1'b1;
`endif

  hold_timer #(.MAX(MAX_HOLD)) u_hold (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (!(in_own && oth_req)),
    .en_i  (in_own && oth_req),
    .tc_o  (hold_tc)
  );

  hold_timer #(.MAX(TURN_N)) u_turn (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_q != TURN),
    .en_i  (state_q == TURN),
    .tc_o  (turn_tc)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    preempt_d = 1'b0;
    winner    = (req_a && req_b) ? tie_winner : (req_b ? MST_B : MST_A);
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // Parked on the winner: skip the turnaround, mux select is already right.
          if (winner == sel_q) begin
            state_d = (winner == MST_B) ? OWN_B : OWN_A;
          end else begin
            state_d = TURN;
            sel_d   = winner;
          end
        end
      end
      OWN_A, OWN_B: begin
        if (!own_req) begin
          last_d = own_id;
          if (oth_req) begin
            state_d = TURN;
            sel_d   = ~own_id;
          end else begin
            state_d = IDLE;
          end
        end else if ((MAX_HOLD != 0) && oth_req && hold_tc && preempt_ok) begin
          state_d   = TURN;
          sel_d     = ~own_id;
          last_d    = own_id;
          preempt_d = 1'b1;
        end
      end
      TURN: begin
        if (turn_tc)
          state_d = ((sel_q == MST_B) ? req_b : req_a)
                    ? ((sel_q == MST_B) ? OWN_B : OWN_A) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= MST_A;
      last_q    <= MST_B;
      preempt_q <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      preempt_q <= preempt_d;
      gnt_a_q   <= (state_d == OWN_A);
      gnt_b_q   <= (state_d == OWN_B);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: directed scenarios followed by random
// request traffic, every cycle compared against a behavioural ownership model.
module tb_bus_arbiter2;

  localparam int MH = 4;
  localparam int TC = 1;

  logic clk = 1'b0;
  logic rst, req_a, req_b;
  logic gnt_a, gnt_b, sel, busy, preempt;

  int checks   = 0;
  int failures = 0;

  bus_arbiter2 #(.MAX_HOLD(MH), .TURN_CYCLES(TC)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  // Model: who owns the bus (-1 nobody), dead cycles left, parked select,
  // last owner, contested-cycle count, and the preempt pulse.
  int m_owner, m_turn_left, m_sel, m_last, m_cont;
  bit m_pre;
  bit fixed_prio;

  task automatic model_reset();
    m_owner = -1; m_turn_left = 0; m_sel = 0; m_last = 1; m_cont = 0; m_pre = 0;
  endtask

  task automatic model_edge(input bit ra, input bit rb);
    bit r[2];
    int x, o, w;
    r[0] = ra; r[1] = rb;
    m_pre = 0;
    if (m_owner >= 0) begin
      x = m_owner; o = 1 - x;
      if (!r[x]) begin
        m_last = x; m_owner = -1; m_cont = 0;
        if (r[o]) begin m_turn_left = TC; m_sel = o; end
      end else if (MH > 0 && r[o] && m_cont == MH - 1 && (!fixed_prio || x == 1)) begin
        m_last = x; m_owner = -1; m_cont = 0;
        m_turn_left = TC; m_sel = o; m_pre = 1;
      end else begin
        m_cont = r[o] ? ((m_cont < MH) ? m_cont + 1 : m_cont) : 0;
      end
    end else if (m_turn_left > 0) begin
      m_turn_left--;
      if (m_turn_left == 0 && r[m_sel]) begin m_owner = m_sel; m_cont = 0; end
    end else if (ra || rb) begin
      w = (ra && rb) ? (fixed_prio ? 0 : 1 - m_last) : (rb ? 1 : 0);
      if (w == m_sel) begin m_owner = w; m_cont = 0; end
      else begin m_turn_left = TC; m_sel = w; end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("gnt_a",   gnt_a,   m_owner == 0);
    chk("gnt_b",   gnt_b,   m_owner == 1);
    chk("sel",     sel,     m_sel[0]);
    chk("busy",    busy,    (m_owner >= 0) || (m_turn_left > 0));
    chk("preempt", preempt, m_pre);
    chk("mutex",   gnt_a & gnt_b, 1'b0);
  endtask

  task automatic step();
    bit ra, rb;
    @(posedge clk);
    ra = req_a; rb = req_b;
    if (rst) model_reset();
    else     model_edge(ra, rb);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    step();
    rst = 1'b0;
  endtask

  int cnt_a, cnt_b;

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    fixed_prio = 1'b1;
`else
    fixed_prio = 1'b0;
`endif
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    model_reset();
    repeat (2) step();
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_sel",   sel,   1'b0);
    chk("rst_busy",  busy,  1'b0);
    rst = 1'b0;

    // A alone: grant one cycle after request, release parks select on A
    req_a = 1'b1; step();
    chk("a_gnt", gnt_a, 1'b1); chk("a_sel", sel, 1'b0); chk("a_busy", busy, 1'b1);
    repeat (4) step();
    req_a = 1'b0; step();
    chk("a_rel_gnt", gnt_a, 1'b0); chk("a_rel_sel", sel, 1'b0);

    // B alone from parked-A: turnaround first
    req_b = 1'b1; step();
    chk("b_turn_sel", sel, 1'b1); chk("b_turn_gnt", gnt_b, 1'b0); chk("b_turn_busy", busy, 1'b1);
    step();
    chk("b_gnt", gnt_b, 1'b1); chk("b_gnt_a", gnt_a, 1'b0);
    repeat (2) step();
    req_b = 1'b0; step(); step();

    // Tie after reset: A first, handover to B after release
    do_reset();
    req_a = 1'b1; req_b = 1'b1; step();
    chk("tie_a_first", gnt_a, 1'b1);
    repeat (3) step();
    req_a = 1'b0; step();
    chk("hand_dead", gnt_a | gnt_b, 1'b0);
    step();
    chk("hand_gnt_b", gnt_b, 1'b1);
    req_b = 1'b0; step();
    for (int k = 0; k < 3; k++) begin
      req_a = 1'b1; req_b = 1'b1;
      repeat (3) step();
      req_a = 1'b0; req_b = 1'b0;
      repeat (3) step();
    end

    // A holds with B contending: preemption after MH contested cycles
    do_reset();
    req_a = 1'b1; step();
    req_b = 1'b1;
    repeat (4) step();
`ifndef ARB_FIXED_PRIO_EN
    chk("pre_pulse", preempt, 1'b1);
    chk("pre_gnt_a", gnt_a, 1'b0);
    step();
    chk("pre_gnt_b", gnt_b, 1'b1);
`endif
    repeat (10) step();
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) step();

    // Asynchronous reset in the middle of a B ownership
    req_b = 1'b1;
    repeat (3) step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_gnt_b", gnt_b, 1'b0); chk("arst_sel", sel, 1'b0); chk("arst_busy", busy, 1'b0);
    req_a = 1'b1; req_b = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("arst_a_first", gnt_a, 1'b1);
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) step();

    // Random transaction traffic
    do_reset();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 500) do_reset();
      if (cnt_a == 0) begin
        req_a = ~req_a;
        cnt_a = req_a ? $urandom_range(12, 1) : $urandom_range(6, 1);
      end
      if (cnt_b == 0) begin
        req_b = ~req_b;
        cnt_b = req_b ? $urandom_range(12, 1) : $urandom_range(6, 1);
      end
      cnt_a--; cnt_b--;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
